// File: rtl/vec_activation.sv
// Serial element-wise activation stage: latches one packed Q8.8 vector, activates one element per cycle,
// then holds the result on a valid/ready output. Define VEC_ACT_GELU_EN for the GELU approximation, else ReLU.
module vec_activation #(
   parameter int unsigned DIM        = 4,
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DIM*DATA_WIDTH-1:0] x_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DIM*DATA_WIDTH-1:0] y_out,
   output logic                      busy,
   output logic                      drop_err,
   input  logic                      clear_err
);

   localparam int unsigned VEC_W = DIM * DATA_WIDTH;
   localparam int unsigned CNT_W = (DIM > 1) ? $clog2(DIM) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIM - 1);

`ifdef VEC_ACT_GELU_EN
   localparam int unsigned T_W = DATA_WIDTH + 1;
   localparam int unsigned P_W = 2 * DATA_WIDTH + 1;
   localparam int unsigned S_W = P_W + 6;
   localparam int unsigned Q_W = S_W - 16;
   localparam logic signed [DATA_WIDTH-1:0] CLAMP_POS = DATA_WIDTH'(768);
   localparam logic signed [DATA_WIDTH-1:0] CLAMP_NEG = -CLAMP_POS;
   localparam logic signed [Q_W-1:0] Q_MAX = Q_W'((1 << (DATA_WIDTH - 1)) - 1);
   localparam logic signed [Q_W-1:0] Q_MIN = ~Q_MAX;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PROC = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [VEC_W-1:0]      buf_q;
   logic [VEC_W-1:0]      y_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  drop_err_q;
   logic                  accept;
   logic                  drop;
   logic [DATA_WIDTH-1:0] x_sel;
   logic [DATA_WIDTH-1:0] y_sel;

   // Element activation; GELU build is the hard-swish style x*(x+3)/6 approximation in Q8.8.
   function automatic logic signed [DATA_WIDTH-1:0] act_f(input logic signed [DATA_WIDTH-1:0] x);
`ifdef VEC_ACT_GELU_EN
      logic signed [T_W-1:0] t;
      logic signed [P_W-1:0] p;
      logic signed [S_W-1:0] s;
      logic signed [Q_W-1:0] q;
      t = {x[DATA_WIDTH-1], x} + T_W'(768);
      p = $signed({{(P_W - DATA_WIDTH){x[DATA_WIDTH-1]}}, x}) *
          $signed({{(P_W - T_W){t[T_W-1]}}, t});
      s = $signed({{(S_W - P_W){p[P_W-1]}}, p}) * $signed(S_W'(43));
      q = Q_W'(s >>> 16);
      if (x <= CLAMP_NEG) begin
         act_f = '0;
      end else if (x >= CLAMP_POS) begin
         act_f = x;
      end else if (q > Q_MAX) begin
         act_f = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
      end else if (q < Q_MIN) begin
         act_f = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
      end else begin
         act_f = q[DATA_WIDTH-1:0];
      end
`else
      act_f = x[DATA_WIDTH-1] ? '0 : x;
`endif
   endfunction

   assign x_sel = buf_q[int'(cnt_q) * DATA_WIDTH +: DATA_WIDTH];
   assign y_sel = act_f(x_sel);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; OUT can hand straight back to PROC when a new vector arrives on the consume edge
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (accept) state_d = S_PROC;
         S_PROC: if (cnt_q == CNT_LAST) state_d = S_OUT;
         S_OUT: begin
            if (out_ready) state_d = accept ? S_PROC : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake and status decode
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state_q)
         S_IDLE: in_ready = 1'b1;
         S_PROC: busy = 1'b1;
         S_OUT: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
         end
         default: in_ready = 1'b0;
      endcase
      accept = in_valid && in_ready;
      drop   = in_valid && !in_ready;
   end

   // Input buffer, element counter, result register and sticky drop flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q      <= '0;
         y_q        <= '0;
         cnt_q      <= '0;
         drop_err_q <= 1'b0;
      end else begin
         if (accept) begin
            buf_q <= x_in;
            cnt_q <= '0;
         end else if (state_q == S_PROC) begin
            y_q[int'(cnt_q) * DATA_WIDTH +: DATA_WIDTH] <= y_sel;
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
         end
         if (drop) begin
            drop_err_q <= 1'b1;
         end else if (clear_err) begin
            drop_err_q <= 1'b0;
         end
      end
   end

   assign y_out    = y_q;
   assign drop_err = drop_err_q;

endmodule

// File: tb/tb_vec_activation.sv
// Scoreboard bench for vec_activation: the model result is queued on acceptance and compared on the output handshake.
// Expectations follow the build: VEC_ACT_GELU_EN selects the GELU model, otherwise ReLU.
module tb_vec_activation;

   localparam int unsigned DIM = 4;
   localparam int unsigned DW  = 16;
   localparam int unsigned VW  = DIM * DW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [VW-1:0] x_in = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [VW-1:0] y_out;
   logic          busy;
   logic          drop_err;
   logic          clear_err = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int acc_cyc  = 0;
   logic prev_ov = 1'b0;
   logic [VW-1:0] sb[$];

   vec_activation #(.DIM(DIM), .DATA_WIDTH(DW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .x_in     (x_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .y_out    (y_out),
      .busy     (busy),
      .drop_err (drop_err),
      .clear_err(clear_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   function automatic logic [15:0] ref_act(input int x);
`ifdef VEC_ACT_GELU_EN
      longint p;
      longint y;
      if (x <= -768) return 16'd0;
      if (x >= 768) return 16'(x);
      p = longint'(x) * longint'(x + 768) * 64'sd43;
      y = p >>> 16;
      if (y > 32767) y = 32767;
      if (y < -32768) y = -32768;
      return 16'(y);
`else
      return (x < 0) ? 16'd0 : 16'(x);
`endif
   endfunction

   function automatic logic [VW-1:0] model(input logic [VW-1:0] v);
      logic [VW-1:0] r;
      r = '0;
      for (int i = 0; i < int'(DIM); i++) begin
         r[i*DW +: DW] = ref_act(int'($signed(v[i*DW +: DW])));
      end
      return r;
   endfunction

   function automatic logic [VW-1:0] pk(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   // Monitor on the falling edge: inputs and outputs are stable and describe the coming rising edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && !prev_ov) check("latency", 64'(cyc - acc_cyc - 1), 64'(DIM));
         if (in_valid && in_ready) begin
            sb.push_back(model(x_in));
            acc_cyc = cyc;
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) check("sb_underflow", 64'd1, 64'd0);
            else check("y_out", y_out, sb.pop_front());
         end
      end
      prev_ov = out_valid;
   end

   task automatic send(input logic [VW-1:0] v);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) check("send_timeout", 64'd0, 64'd1);
      in_valid = 1'b1;
      x_in     = v;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out_valid();
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!out_valid) check("out_valid_timeout", 64'd0, 64'd1);
   endtask

   task automatic run_hold(input string tag, input logic [VW-1:0] v, input logic [VW-1:0] exp);
      out_ready = 1'b0;
      send(v);
      wait_out_valid();
      check(tag, y_out, exp);
      out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [VW-1:0] basic_exp;
      logic [VW-1:0] ones_exp;
      int n;
`ifdef VEC_ACT_GELU_EN
      basic_exp = pk(172, 430, -86, 768);
      ones_exp  = pk(172, 172, 172, 172);
`else
      basic_exp = pk(256, 512, 0, 768);
      ones_exp  = pk(256, 256, 256, 256);
`endif

      // Reset state
      #12;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_y_out", y_out, 64'd0);
      check("rst_drop_err", 64'(drop_err), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic vector with back-pressure and a drop during PROC
      out_ready = 1'b0;
      send(pk(256, 512, -256, 768));
      check("proc_busy", 64'(busy), 64'd1);
      check("proc_in_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b1;
      x_in     = pk(-1, -2, -3, -4);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("drop_set", 64'(drop_err), 64'd1);
      wait_out_valid();
      check("basic_y", y_out, basic_exp);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_y", y_out, basic_exp);
      end
      clear_err = 1'b1;
      @(posedge clk); #1;
      clear_err = 1'b0;
      check("drop_clear", 64'(drop_err), 64'd0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("idle_after_out", 64'(in_ready && !out_valid && !busy), 64'd1);

      // Clamp region
      run_hold("clamp_y", pk(-768, -1024, 1024, 0), pk(0, 0, 1024, 0));

      // Back-to-back through the OUT->PROC bypass
      out_ready = 1'b1;
      send(pk(100, -100, 700, -700));
      wait_out_valid();
      send(pk(767, -767, 1, -1));
      check("b2b_busy", 64'(busy), 64'd1);
      check("b2b_out_valid", 64'(out_valid), 64'd0);
      wait_out_valid();
      @(posedge clk); #1;

      // Random vectors, including saturation-free mid range and out-of-range values
      for (int k = 0; k < 6; k++) begin
         send({16'($urandom), 16'($urandom_range(0, 1535) - 768), 16'($urandom), 16'($urandom_range(0, 1535) - 768)});
      end

      // Reset in the middle of PROC, with a pending drop flag
      send(pk(300, 400, 500, 600));
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("pre_rst_drop", 64'(drop_err), 64'd1);
      rst_n = 1'b0;
      #1;
      check("arst_in_ready", 64'(in_ready), 64'd1);
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_y_out", y_out, 64'd0);
      check("arst_drop_err", 64'(drop_err), 64'd0);
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_hold("post_rst_y", pk(256, 256, 256, 256), ones_exp);

      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/vec_activation.md
# vec_activation

Serial element-wise activation stage that sits directly downstream of `linear_layer`. It consumes one packed Q8.8 output vector per transaction and applies the activation to one element per cycle. It then presents the activated vector to the next transformer stage over a valid/ready handshake. Because `linear_layer` emits a single-cycle `valid_out` pulse with no back-pressure, this block also flags any vector it is not able to accept.

## Interface
- `DIM`, 4, vector length in elements (≥1).
- `DATA_WIDTH`, 16, element width, signed Q8.8; arithmetic constants below assume 16.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input vector present on `x_in`.
- `in_ready` out 1: block can accept a vector this cycle.
- `x_in` in DIM*DATA_WIDTH: packed input; element i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `out_valid` out 1: `y_out` holds a complete activated vector.
- `out_ready` in 1: downstream consumes `y_out`.
- `y_out` out DIM*DATA_WIDTH: packed result, same element order as input.
- `busy` out 1: high in PROC.
- `drop_err` out 1: sticky; set when `in_valid` is high while `in_ready` is low.
- `clear_err` in 1: synchronous clear of `drop_err`.

## Operation
- FSM has three states: IDLE, PROC and OUT.
- **IDLE → PROC:** on an edge with `in_valid && in_ready`:
  - `x_in` is latched into an internal buffer.
  - The element counter is cleared to 0.
- **PROC:** on each edge, element `cnt` of the buffer is activated and written to the result register, then `cnt` increments.
  - After element DIM-1 the FSM goes to OUT.
- **OUT:** `out_valid` is held high and `y_out` is held stable until an edge with `out_ready` high.
  - If `in_valid` is also high on that edge, the new vector is latched and the FSM goes straight to PROC.
  - Otherwise the FSM goes to IDLE.
- `in_ready` = (state==IDLE) || (state==OUT && out_ready).
- `drop_err` is set on any edge with `in_valid && !in_ready`. A dropped vector is discarded and the buffer is unchanged.
- If `clear_err` and a drop occur on the same edge, the set wins.
- Activation f(x), with x a signed 16-bit Q8.8 value and GELU_EN defined:
  - x ≤ -768 (-3.0) → 0.
  - x ≥ 768 (3.0) → x.
  - Otherwise: t = x + 768 (17-bit signed); p = x*t (33-bit signed, Q16.16); y = (p*43) >>> 16, using an arithmetic shift (floor); then saturate to [-32768, 32767].
- Activation f(x) without GELU_EN: y = (x < 0) ? 0 : x.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `drop_err`=0, `y_out`=0, buffer and counter 0.
- Latency: if a vector is accepted on edge k, `out_valid` rises after edge k+DIM.
- Throughput: one vector per DIM+1 cycles with `out_ready` tied high, because the OUT→PROC bypass removes the IDLE cycle.
- `y_out` changes only in PROC. Elements not yet processed hold their previous values, but `out_valid` is low throughout PROC.
- Deasserting `rst_n` at any point aborts the transaction. Every output returns to its reset value immediately, without waiting for a clock edge.
- `out_ready` is ignored while `out_valid` is low. `in_valid` while in PROC is a drop.

## Configuration
- `VEC_ACT_GELU_EN` defined: the hard-swish GELU approximation above is compiled in, including one 17×16 multiplier and one ×43 constant multiply.
- `VEC_ACT_GELU_EN` not defined: ReLU only, with no multiplier.
- The FSM, latency and handshake are identical in both builds.

## Test plan
- **Reset:** hold `rst_n`=0 → `in_ready`=1, `out_valid`=0, `y_out`=0, `drop_err`=0.
- **GELU_EN, basic vector:** send x = [1.0, 2.0, -1.0, 3.0] = [256, 512, -256, 768] with `out_ready`=1.
  - Expect `y_out` = [172, 430, -86, 768].
  - `out_valid` must rise exactly 4 edges after acceptance.
- **Clamp region:** send x = [-768, -1024, 1024, 0] → GELU build gives [0, 0, 1024, 0]. The ReLU build gives [0, 0, 1024, 0] as well.
- **Back-pressure:** hold `out_ready`=0 for 10 cycles after `out_valid` rises → `y_out` stays stable and `out_valid` stays high.
  - An `in_valid` pulse during PROC sets `drop_err`.
  - `clear_err` then clears it.
- **Back-to-back:** assert `out_ready` and a new `in_valid` on the same edge in OUT → the new vector is accepted with no IDLE cycle, and the next `out_valid` follows 4 edges later.
- **Reset mid-PROC:** assert `rst_n`=0 after 2 elements → everything returns to reset values.
  - A subsequent full vector [256, 256, 256, 256] produces [172, 172, 172, 172] (GELU build).
